nibble_compare_sequencer: RTL and testbench
===========================================

// Module: nibble_compare_sequencer
// PURPOSE
// Multi-cycle magnitude comparator controller for WIDTH-bit unsigned operands.
// Reuses one 4-bit compare slice (gt/eq/lt), applied one nibble per clock, MSB nibble first.
// An FSM owns a valid/ready start handshake, the nibble index counter and the sticky result.
// Used where wide compares are rare and area matters more than latency.
// PARAMETERS
// WIDTH  16  operand width in bits; must be a multiple of 4 and >= 4
// (derived) NIB = WIDTH/4 nibbles; CW = $clog2(NIB+1) count width
// PORTS
// clk          in   1      rising-edge clock
// rst          in   1      synchronous, active-high reset
// start_valid  in   1      request to compare a,b
// start_ready  out  1      block can accept a request (high only in IDLE)
// a            in   WIDTH  operand A, sampled on accept
// b            in   WIDTH  operand B, sampled on accept
// busy         out  1      compare in progress (CMP state)
// done         out  1      one-cycle pulse: gt/eq/lt/nib_count now valid
// gt           out  1      A > B
// eq           out  1      A == B
// lt           out  1      A < B
// nib_count    out  CW     number of nibble compares used by last operation
// BEHAVIOUR
// - Reset: state=IDLE; start_ready=1; busy=0; done=0; gt=eq=lt=0; nib_count=0.
//   rst overrides everything, incl. mid-CMP: operation discarded, no done pulse.
// - States: IDLE -> CMP -> DONE -> IDLE.
// - IDLE: accept when start_valid & start_ready at edge T. Latch a,b; idx=NIB-1;
//   clear gt/eq/lt, nib_count=0; go CMP. start_valid ignored in CMP/DONE.
// - CMP: each cycle compare a[4*idx+:4] vs b[4*idx+:4] (4-bit slice: gt/eq/lt).
//   nib_count increments by 1 per CMP cycle.
//   First unequal nibble sets the sticky result (gt or lt); later nibbles never change it.
//   Exit when idx==0, or on first mismatch if early exit is enabled (see CONFIGURATION).
//   On exit with no mismatch seen: eq=1. Else idx decrements.
// - DONE: done=1 for exactly this cycle; start_ready=0; next cycle IDLE.
// - Latency: CMP occupies T+1..T+k; done high in cycle T+k+1; k = nib_count.
//   Next request accepted no earlier than cycle T+k+2.
// - gt/eq/lt are registered and one-hot from the done cycle until the next accept.
//   They are all 0 from that accept until the next done.
// - busy == (state==CMP); start_ready == (state==IDLE).
// - Unsigned compare only; a,b are not sampled after accept (may change freely).
// CONFIGURATION
// EARLY_EXIT_EN defined:
//   CMP exits on the first unequal nibble; k = (index from MSB of first mismatch)+1,
//   or NIB if equal.
// EARLY_EXIT_EN undefined:
//   CMP always runs NIB cycles (k=NIB, fixed latency); result still from first mismatch.
// TESTING (WIDTH=16, accept at edge T)
// 1. a=16'h1234,b=16'h1234 -> eq=1,gt=lt=0, done at T+5, nib_count=4 (both configs).
// 2. a=16'h8000,b=16'h7FFF -> gt=1; EARLY_EXIT_EN: done T+2, nib_count=1;
//    undefined: done T+5, nib_count=4.
// 3. a=16'h1230,b=16'h1231 -> lt=1, done T+5, nib_count=4 (both configs).
// 4. a=16'h0F00,b=16'h0E00 accepted; hold start_valid=1 with a=0,b=FFFF during CMP/DONE
//    -> start_ready=0, request ignored; result gt=1.
//    Re-accepted only in IDLE, yielding lt=1.
// 5. rst=1 in 2nd CMP cycle -> next cycle start_ready=1, busy=0, gt/eq/lt=0,
//    nib_count=0; no done pulse ever for that request.
// 6. Back-to-back: start_valid held high over two requests -> accepts spaced k+2 cycles;
//    gt/eq/lt read 0 between accept and done; exactly one done pulse per accept.

Source files
------------

// File: rtl/nibble_compare_sequencer.sv
// nibble_compare_sequencer: serial MSB-first nibble magnitude comparator; define EARLY_EXIT_EN to stop at the first unequal nibble
module nibble_compare_sequencer #(
    parameter int WIDTH = 16,
    localparam int NIB = WIDTH / 4,
    localparam int CW = $clog2(NIB + 1),
    localparam int IW = (NIB > 1) ? $clog2(NIB) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic [CW-1:0]    nib_count
);
    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] a_r, b_r;
    logic [IW-1:0] idx;
    logic sgt, slt, ngt, nlt, fin, first;
    logic [3:0] na, nb;
    assign start_ready = state == IDLE;
    assign busy = state == CMP;
    assign done = state == DONE;
    // nibble slice compare, sticky merge and exit decision for the current CMP cycle
    always_comb begin
        na = a_r[4*idx +: 4];
        nb = b_r[4*idx +: 4];
        first = !(sgt || slt);
        ngt = sgt || (first && na > nb);
        nlt = slt || (first && na < nb);
`ifdef EARLY_EXIT_EN
        fin = idx == '0 || na != nb;
`else
        fin = idx == '0;
`endif
    end
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    // next state: IDLE -> CMP -> DONE -> IDLE
    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = start_valid ? CMP : IDLE;
            CMP: state_n = fin ? DONE : CMP;
            default: state_n = IDLE;
        endcase
    end
    // operand capture, nibble walk and registered result; outputs stay clear until exit
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r <= '0;
            b_r <= '0;
            idx <= '0;
            sgt <= 1'b0;
            slt <= 1'b0;
            gt <= 1'b0;
            eq <= 1'b0;
            lt <= 1'b0;
            nib_count <= '0;
        end else if (start_valid && start_ready) begin
            a_r <= a;
            b_r <= b;
            idx <= IW'(NIB - 1);
            sgt <= 1'b0;
            slt <= 1'b0;
            gt <= 1'b0;
            eq <= 1'b0;
            lt <= 1'b0;
            nib_count <= '0;
        end else if (busy) begin
            nib_count <= nib_count + CW'(1);
            sgt <= ngt;
            slt <= nlt;
            idx <= idx - IW'(1);
            if (fin) begin
                gt <= ngt;
                lt <= nlt;
                eq <= !(ngt || nlt);
            end
        end
    end
endmodule

// File: tb/tb_nibble_compare_sequencer.sv
// tb_nibble_compare_sequencer: directed vectors, scoreboard queue filled at accept, monitor checks on done
module tb_nibble_compare_sequencer;
`ifdef EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif
    typedef struct {
        logic g, e, l;
        int k;
        int acc;
    } exp_t;
    logic clk = 1'b0, rst = 1'b1, start_valid = 1'b0;
    logic start_ready, busy, done, gt, eq, lt;
    logic [15:0] a = '0, b = '0;
    logic [2:0] nib_count;
    int cyc = 0, nchk = 0, nfail = 0;
    exp_t sb[$];
    nibble_compare_sequencer #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .a(a), .b(b), .busy(busy), .done(done), .gt(gt), .eq(eq), .lt(lt),
        .nib_count(nib_count)
    );
    always #5 clk = ~clk;
    // edge counter used to measure accept-to-done latency
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string n, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask
    task automatic wait_ready();
        int t = 0;
        @(negedge clk);
        while (!start_ready && t < 50) begin
            t++;
            @(negedge clk);
        end
        if (!start_ready) chk("ready_timeout", 0, 1);
    endtask
    task automatic push(input logic g, e, l, input int ke, kf, input int acc);
        exp_t x;
        x.g = g; x.e = e; x.l = l; x.k = EE ? ke : kf; x.acc = acc;
        sb.push_back(x);
    endtask
    // issue one request and leave start_valid high; returns the accept edge count
    task automatic req(input logic [15:0] av, bv, input logic g, e, l, input int ke, kf,
                       output int acc);
        wait_ready();
        start_valid = 1'b1; a = av; b = bv;
        @(posedge clk); #1;
        acc = cyc;
        push(g, e, l, ke, kf, acc);
    endtask
    // start_valid held across two requests; second accept expected k1+2 edges after the first
    task automatic pair(input logic [15:0] a1, b1, input logic g1, e1, l1, input int ke1, kf1,
                        input logic [15:0] a2, b2, input logic g2, e2, l2, input int ke2, kf2);
        int acc;
        req(a1, b1, g1, e1, l1, ke1, kf1, acc);
        a = a2; b = b2;
        push(g2, e2, l2, ke2, kf2, acc + (EE ? ke1 : kf1) + 2);
        wait_ready();
        @(posedge clk); #1;
        start_valid = 1'b0; a = $urandom; b = $urandom;
    endtask
    // monitor: results hidden while busy, and each done pulse matches the oldest expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (busy) begin
                chk("busy_result_zero", {gt, eq, lt}, 0);
                chk("busy_ready_low", start_ready, 0);
            end
            if (done) begin
                if (sb.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    exp_t x;
                    x = sb.pop_front();
                    chk("gt", gt, x.g);
                    chk("eq", eq, x.e);
                    chk("lt", lt, x.l);
                    chk("nib_count", nib_count, x.k);
                    chk("latency", cyc - x.acc, x.k);
                    chk("done_ready_low", start_ready, 0);
                end
            end
        end
    end
    initial begin
        int acc, t;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", start_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_res", {gt, eq, lt}, 0);
        chk("rst_count", nib_count, 0);
        rst = 1'b0;
        req(16'h1234, 16'h1234, 0, 1, 0, 4, 4, acc); start_valid = 1'b0;
        req(16'h8000, 16'h7FFF, 1, 0, 0, 1, 4, acc); start_valid = 1'b0;
        req(16'h1230, 16'h1231, 0, 0, 1, 4, 4, acc); start_valid = 1'b0;
        req(16'h0000, 16'h0000, 0, 1, 0, 4, 4, acc); start_valid = 1'b0;
        req(16'h00A0, 16'h00B0, 0, 0, 1, 3, 4, acc); start_valid = 1'b0;
        pair(16'h0F00, 16'h0E00, 1, 0, 0, 2, 4, 16'h0000, 16'hFFFF, 0, 0, 1, 1, 4);
        pair(16'hABCD, 16'hABCE, 0, 0, 1, 4, 4, 16'hFFFF, 16'h0000, 1, 0, 0, 1, 4);
        // reset in the second CMP cycle discards the request with no done pulse
        wait_ready();
        start_valid = 1'b1; a = 16'h5555; b = 16'h5555;
        @(posedge clk); #1;
        start_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_ready", start_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_res", {gt, eq, lt}, 0);
        chk("mid_rst_count", nib_count, 0);
        repeat (8) @(posedge clk);
        req(16'h4321, 16'h4320, 1, 0, 0, 4, 4, acc); start_valid = 1'b0;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            t++;
            @(posedge clk);
        end
        chk("scoreboard_drained", sb.size(), 0);
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
